// File: rtl/spi_cmd_pkg.sv
// Shared state encoding and command opcodes for the SPI command sequencer.
package spi_cmd_pkg;

    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, RAM_WR, CONF} cmd_state_t;

    localparam logic [7:0] CMD_SET_ADDR = 8'h2A;
    localparam logic [7:0] CMD_RAM_WR   = 8'h2C;
    localparam logic [7:0] CMD_CONF_WR  = 8'h3A;
    localparam logic [7:0] CMD_FLUSH    = 8'h2F;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Turns the received SPI byte stream into pixel-RAM writes, config writes and frame-flush pulses.
// Every output is registered, so each strobe appears the cycle after its byte_rdy_in.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int RAM_DEPTH = 768
) (
    input  logic              clk_in,
    input  logic              spi_rst_n,
    input  logic              spi_dc_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic              ram_wr_en_out,
    output logic [ADDR_W-1:0] ram_wr_addr_out,
    output logic [7:0]        ram_wr_data_out,
    output logic              cfg_wr_en_out,
    output logic [7:0]        cfg_wr_data_out,
    output logic              frame_rdy_out
);

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] clamp_addr(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= DEPTH_LIM) ? '0 : a;
    endfunction

    logic              dc_sync_p0, dc_sync_p1;
    cmd_state_t        state, state_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic              is_cmd, is_data;
    logic              ram_wr_en_d, cfg_wr_en_d, frame_rdy_d;
    logic [ADDR_W-1:0] ram_wr_addr_d;
    logic [7:0]        ram_wr_data_d, cfg_wr_data_d;

    assign is_cmd  = byte_rdy_in & ~dc_sync_p1;
    assign is_data = byte_rdy_in &  dc_sync_p1;

    // dc synchronizer boundary: dc_sync_p1 is the value sampled alongside byte_rdy_in
    always_ff @(posedge clk_in or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            dc_sync_p0 <= 1'b0;
            dc_sync_p1 <= 1'b0;
        end else begin
            dc_sync_p0 <= spi_dc_in;
            dc_sync_p1 <= dc_sync_p0;
        end
    end

    always_ff @(posedge clk_in or negedge spi_rst_n) begin
        if (!spi_rst_n) state <= IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (is_cmd) begin
            case (byte_data_in)
                CMD_SET_ADDR: state_d = ADDR_HI;
                CMD_RAM_WR:   state_d = RAM_WR;
                CMD_CONF_WR:  state_d = CONF;
                default:      state_d = IDLE;
            endcase
        end else if (is_data) begin
            case (state)
                ADDR_HI: state_d = ADDR_LO;
                ADDR_LO: state_d = IDLE;
                CONF:    state_d = IDLE;
                default: state_d = state;
            endcase
        end
    end

    always_comb begin
        addr_d        = addr;
        ram_wr_en_d   = 1'b0;
        ram_wr_addr_d = '0;
        ram_wr_data_d = '0;
        cfg_wr_en_d   = 1'b0;
        cfg_wr_data_d = '0;
        frame_rdy_d   = 1'b0;
        if (is_cmd) begin
            frame_rdy_d = (byte_data_in == CMD_FLUSH);
        end else if (is_data) begin
            case (state)
                ADDR_HI: addr_d = {byte_data_in[ADDR_W-9:0], addr[7:0]};
                ADDR_LO: addr_d = clamp_addr({addr[ADDR_W-1:8], byte_data_in});
                RAM_WR: begin
                    ram_wr_en_d   = 1'b1;
                    ram_wr_addr_d = addr;
                    ram_wr_data_d = byte_data_in;
                    addr_d        = next_addr(addr);
                end
                CONF: begin
                    cfg_wr_en_d   = 1'b1;
                    cfg_wr_data_d = byte_data_in;
                end
                default: addr_d = addr;
            endcase
        end
    end

    // output register boundary: strobes land one cycle after their byte
    always_ff @(posedge clk_in or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            addr            <= '0;
            ram_wr_en_out   <= 1'b0;
            ram_wr_addr_out <= '0;
            ram_wr_data_out <= '0;
            cfg_wr_en_out   <= 1'b0;
            cfg_wr_data_out <= '0;
            frame_rdy_out   <= 1'b0;
        end else begin
            addr            <= addr_d;
            ram_wr_en_out   <= ram_wr_en_d;
            ram_wr_addr_out <= ram_wr_addr_d;
            ram_wr_data_out <= ram_wr_data_d;
            cfg_wr_en_out   <= cfg_wr_en_d;
            cfg_wr_data_out <= cfg_wr_data_d;
            frame_rdy_out   <= frame_rdy_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: directed byte sequences push expected strobes,
// a negedge monitor pops and compares each strobe the DUT produces.
module tb_spi_cmd_ctrl;

    localparam int K_NONE = 0;
    localparam int K_RAM  = 1;
    localparam int K_CFG  = 2;
    localparam int K_FRM  = 3;

    typedef struct {
        int         kind;
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       spi_rst_n = 1'b0;
    logic       spi_dc_in = 1'b0;
    logic       byte_rdy_in = 1'b0;
    logic [7:0] byte_data_in = 8'h00;
    logic       ram_wr_en_out;
    logic [9:0] ram_wr_addr_out;
    logic [7:0] ram_wr_data_out;
    logic       cfg_wr_en_out;
    logic [7:0] cfg_wr_data_out;
    logic       frame_rdy_out;

    exp_t q[$];
    exp_t mon_e;
    int   mon_kind;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic cur_dc = 1'b0;

    spi_cmd_ctrl #(.ADDR_W(10), .RAM_DEPTH(768)) dut (
        .clk_in          (clk_in),
        .spi_rst_n       (spi_rst_n),
        .spi_dc_in       (spi_dc_in),
        .byte_rdy_in     (byte_rdy_in),
        .byte_data_in    (byte_data_in),
        .ram_wr_en_out   (ram_wr_en_out),
        .ram_wr_addr_out (ram_wr_addr_out),
        .ram_wr_data_out (ram_wr_data_out),
        .cfg_wr_en_out   (cfg_wr_en_out),
        .cfg_wr_data_out (cfg_wr_data_out),
        .frame_rdy_out   (frame_rdy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_ram_en"},   int'(ram_wr_en_out),   0);
        check({nm, "_ram_addr"}, int'(ram_wr_addr_out), 0);
        check({nm, "_ram_data"}, int'(ram_wr_data_out), 0);
        check({nm, "_cfg_en"},   int'(cfg_wr_en_out),   0);
        check({nm, "_cfg_data"}, int'(cfg_wr_data_out), 0);
        check({nm, "_frame"},    int'(frame_rdy_out),   0);
    endtask

    // Called at a negedge; returns at the following negedge with byte_rdy_in low.
    task automatic send(input logic dc, input logic [7:0] b, input int kind,
                        input logic [9:0] ea, input logic [7:0] ed);
        exp_t e;
        if (dc !== cur_dc) begin
            byte_rdy_in = 1'b0;
            spi_dc_in   = dc;
            cur_dc      = dc;
            repeat (3) @(negedge clk_in);
        end
        byte_rdy_in  = 1'b1;
        byte_data_in = b;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.addr = ea;
            e.data = ed;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk_in);
        byte_rdy_in = 1'b0;
    endtask

    always @(negedge clk_in) begin
        if (ram_wr_en_out || cfg_wr_en_out || frame_rdy_out) begin
            if ($countones({ram_wr_en_out, cfg_wr_en_out, frame_rdy_out}) > 1) begin
                vectors++;
                miscompares++;
                $display("FAIL multi_strobe: ram=%0b cfg=%0b frame=%0b at cycle %0d, expected one",
                         ram_wr_en_out, cfg_wr_en_out, frame_rdy_out, cyc);
            end
            mon_kind = ram_wr_en_out ? K_RAM : (cfg_wr_en_out ? K_CFG : K_FRM);
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected none", mon_kind, cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_kind != mon_e.kind || cyc != mon_e.cyc ||
                    (mon_kind == K_RAM && (ram_wr_addr_out != mon_e.addr || ram_wr_data_out != mon_e.data)) ||
                    (mon_kind == K_CFG && cfg_wr_data_out != mon_e.data)) begin
                    miscompares++;
                    $display("FAIL strobe: got kind %0d addr 0x%0h ram 0x%0h cfg 0x%0h cyc %0d, expected kind %0d addr 0x%0h data 0x%0h cyc %0d",
                             mon_kind, ram_wr_addr_out, ram_wr_data_out, cfg_wr_data_out, cyc,
                             mon_e.kind, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_strobe: got none at cycle %0d, expected kind %0d addr 0x%0h data 0x%0h",
                     cyc, mon_e.kind, mon_e.addr, mon_e.data);
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        check_idle("reset");
        spi_rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // data byte with no command is ignored
        send(1'b1, 8'h55, K_NONE, 10'h0, 8'h00);
        repeat (2) @(negedge clk_in);
        check_idle("idle");

        // addressed write
        send(1'b0, 8'h2A, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h01, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h10, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'hAA, K_RAM, 10'h110, 8'hAA);
        send(1'b1, 8'hBB, K_RAM, 10'h111, 8'hBB);

        // wrap at the last RAM location, back-to-back bytes
        send(1'b0, 8'h2A, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h02, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'hFF, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'hC1, K_RAM, 10'd767, 8'hC1);
        send(1'b1, 8'hC2, K_RAM, 10'd0,   8'hC2);
        send(1'b1, 8'hC3, K_RAM, 10'd1,   8'hC3);

        // out-of-range address clamps to 0
        send(1'b0, 8'h2A, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h03, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h00, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'hD0, K_RAM, 10'd0, 8'hD0);

        // interrupted SET_ADDR keeps the new upper bits (addr was 1 -> 0x101)
        send(1'b0, 8'h2A, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h01, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'hE0, K_RAM, 10'h101, 8'hE0);

        // config takes one byte only; unknown command idles; flush pulses once
        send(1'b0, 8'h3A, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h40, K_CFG, 10'h0, 8'h40);
        send(1'b1, 8'h41, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h00, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h77, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2F, K_FRM, 10'h0, 8'h00);
        repeat (2) @(negedge clk_in);
        check_idle("post_flush");

        // streaming write aborted by reset while a strobe is high
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h10, K_RAM, 10'h102, 8'h10);
        send(1'b1, 8'h11, K_RAM, 10'h103, 8'h11);
        send(1'b1, 8'h12, K_RAM, 10'h104, 8'h12);
        #1;
        spi_rst_n = 1'b0;
        #1;
        check("abort_ram_en", int'(ram_wr_en_out), 0);
        check("abort_ram_addr", int'(ram_wr_addr_out), 0);
        repeat (3) @(negedge clk_in);
        check_idle("in_reset");
        spi_rst_n = 1'b1;
        repeat (3) @(negedge clk_in);

        // after release: data without command ignored, address restarts at 0
        send(1'b1, 8'h99, K_NONE, 10'h0, 8'h00);
        send(1'b0, 8'h2C, K_NONE, 10'h0, 8'h00);
        send(1'b1, 8'h5A, K_RAM, 10'd0, 8'h5A);
        repeat (4) @(negedge clk_in);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
